hazard_unit: RTL and testbench

- Producer-side counterpart to the pipeline's operand-forwarding logic.
- Tracks in-flight register writes in a shadow of the EX/MEM/WB pipeline registers.
- Detects read-after-write hazards that forwarding cannot cover, plus branch/jump redirects and I/D memory waits.
- Drives every pipeline-register enable and flush; sits beside the ID stage in the 5-stage MIPS datapath.

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/hazard_match.sv | 20 ++
 rtl/hazard_unit.sv | 137 +++++++++++++
 tb/tb_hazard_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the hazard unit.
//   regbits_t   : architectural register index
//   sb_entry_t  : shadow copy of one pipeline register's write-back info
//   hazstate_t  : hazard-unit wait state
package cpu_types_pkg;
  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef struct packed {
    logic     valid;
    regbits_t wsel;
    logic     is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {RUN, DWAIT, IWAIT} hazstate_t;
endpackage

// File: rtl/hazard_match.sv
// Compares the ID-stage sources against one shadow entry.
//   id_rs/id_rt, *_used : ID source registers and whether each is read
//   entry               : shadow entry for one in-flight stage
//   hit                 : ID reads the register this entry will write
//   hit_load            : hit, and the writer is a load
module hazard_match import cpu_types_pkg::*; (
  input  regbits_t  id_rs,
  input  regbits_t  id_rt,
  input  logic      id_rs_used,
  input  logic      id_rt_used,
  input  sb_entry_t entry,
  output logic      hit,
  output logic      hit_load
);
  // $0 is hardwired, so a write to it never creates a dependency.
  assign hit = entry.valid && (entry.wsel != '0) &&
               ((id_rs_used && (id_rs == entry.wsel)) ||
                (id_rt_used && (id_rt == entry.wsel)));
  assign hit_load = hit && entry.is_load;
endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage pipeline: shadows in-flight register writes
// (EX/MEM/WB), detects RAW stalls, branch redirects and I/D memory waits,
// and drives all pipeline-register enables and flushes.
//   CLK, nRST          : clock, synchronous active-low reset
//   ihit, dhit         : fetch / data access complete this cycle
//   mem_dreq           : MEM-stage instruction accesses memory
//   id_*               : ID-stage sources, destination, load flag
//   ex_redirect        : EX resolved a taken branch / jump
//   *_en, *_flush      : stage-register enables and bubble inserts
//   stall_cnt          : saturating count of dependency stall cycles
// Build option: FORWARDING_EN defined -> stall only on load-use (EX load);
// undefined -> stall on any match in EX, MEM or WB.
module hazard_unit import cpu_types_pkg::*; #(
  parameter int NREGS = 32,
  parameter int DEPTH = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dreq,
  input  regbits_t    id_rs,
  input  regbits_t    id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic        id_regwr,
  input  regbits_t    id_wsel,
  input  logic        id_memread,
  input  logic        ex_redirect,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [15:0] stall_cnt
);
  hazstate_t             state, next_state;
  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             ex_in;
  logic      [DEPTH-1:0] stage_en, hit, hit_load;
  logic                  dep_stall, count_stall, dwait;
  logic                  unused_hits;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    hazard_match u_match (
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_rs_used(id_rs_used),
      .id_rt_used(id_rt_used),
      .entry     (sb[i]),
      .hit       (hit[i]),
      .hit_load  (hit_load[i])
    );
    if (i == 0)      begin : g_ex  assign stage_en[i] = idex_en;  end
    else if (i == 1) begin : g_mem assign stage_en[i] = exmem_en; end
    else             begin : g_wb  assign stage_en[i] = memwb_en; end
  end

`ifdef FORWARDING_EN
  // Forwarding covers everything except a load result needed next cycle.
  assign dep_stall   = hit_load[0];
  assign unused_hits = ^{hit, hit_load};
`else
  assign dep_stall   = |hit;
  assign unused_hits = ^hit_load;
`endif

  // A flushed ID/EX slot is a bubble and must not look like a writer.
  assign ex_in = '{valid:   id_regwr && (id_wsel != '0) &&
                            (int'(id_wsel) < NREGS) && !idex_flush,
                   wsel:    id_wsel,
                   is_load: id_memread};

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      sb        <= '0;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (stage_en[0]) sb[0] <= ex_in;
      for (int i = 1; i < DEPTH; i++)
        if (stage_en[i]) sb[i] <= sb[i-1];
      if (count_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // In DWAIT the MEM stage is frozen, so only dhit releases it. On release
  // the cycle is evaluated exactly like RUN, which lets a redirect held in
  // the frozen EX stage be honoured on the exit cycle.
  always_comb begin
    dwait = (state == DWAIT) ? !dhit : (mem_dreq && !dhit);
  end

  always_comb begin
    next_state  = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    count_stall = 1'b0;
    if (!nRST) begin
      next_state = RUN;
    end else if (dwait) begin
      next_state = DWAIT;
    end else if (!ihit) begin
      // Front end holds; back end drains with a bubble behind it.
      next_state = IWAIT;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      idex_flush = 1'b1;
    end else begin
      next_state = RUN;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      if (ex_redirect) begin
        // The stalled consumer is on the wrong path anyway.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (dep_stall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_flush  = 1'b1;
        count_stall = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit, dhit, mem_dreq;
  logic [4:0]  id_rs, id_rt, id_wsel;
  logic        id_rs_used, id_rt_used, id_regwr, id_memread, ex_redirect;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: which stage holds which pending write, plus a data-wait flag.
  bit m_dw;
  bit m_v[3];
  int m_w[3];
  bit m_l[3];
  int m_cnt;

  logic [6:0]  s_out;
  logic [15:0] s_cnt;

  localparam logic [6:0] ALL0  = 7'b0000000;
  localparam logic [6:0] NORM  = 7'b1111100;
  localparam logic [6:0] STALL = 7'b0011101;
  localparam logic [6:0] REDIR = 7'b1111111;

  hazard_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_regwr(id_regwr), .id_wsel(id_wsel), .id_memread(id_memread),
    .ex_redirect(ex_redirect), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic bit mhit(int i);
    return m_v[i] && (m_w[i] != 0) &&
           ((id_rs_used && (int'(id_rs) == m_w[i])) ||
            (id_rt_used && (int'(id_rt) == m_w[i])));
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step(input string name);
    logic [6:0] e;
    bit st, up;
    @(negedge CLK);
`ifdef FORWARDING_EN
    st = mhit(0) && m_l[0];
`else
    st = mhit(0) || mhit(1) || mhit(2);
`endif
    up = 1'b0;
    if (!nRST) e = ALL0;
    else if (m_dw ? !dhit : (mem_dreq && !dhit)) e = ALL0;
    else if (!ihit) e = STALL;
    else if (ex_redirect) e = REDIR;
    else if (st) begin e = STALL; up = 1'b1; end
    else e = NORM;
    s_out = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
    s_cnt = stall_cnt;
    checks++;
    if (s_out !== e) begin
      errors++;
      $display("FAIL %s outs got %b want %b", name, s_out, e);
    end
    checks++;
    if (s_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL %s stall_cnt got %0d want %0d", name, s_cnt, m_cnt);
    end
    @(posedge CLK);
    if (!nRST) begin
      m_dw = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_w[i] = 0; m_l[i] = 0; end
    end else begin
      m_dw = (e == ALL0);
      if (e[2]) begin m_v[2] = m_v[1]; m_w[2] = m_w[1]; m_l[2] = m_l[1]; end
      if (e[3]) begin m_v[1] = m_v[0]; m_w[1] = m_w[0]; m_l[1] = m_l[0]; end
      if (e[4]) begin
        m_v[0] = id_regwr && (id_wsel != 0) && !e[0];
        m_w[0] = int'(id_wsel);
        m_l[0] = id_memread;
      end
      if (up && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic idle();
    ihit = 1; dhit = 1; mem_dreq = 0; ex_redirect = 0;
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_regwr = 0; id_wsel = 0; id_memread = 0;
  endtask

  task automatic rst();
    idle();
    nRST = 0;
    step("rst0"); chk("rst_outs", {9'd0, s_out}, {9'd0, ALL0});
    step("rst1"); chk("rst_cnt", s_cnt, 16'd0);
    nRST = 1;
  endtask

  task automatic use2();   // add $3,$2,$4
    idle(); id_rs = 2; id_rt = 4; id_rs_used = 1; id_rt_used = 1; id_regwr = 1; id_wsel = 3;
  endtask

  task automatic lw2();
    idle(); id_regwr = 1; id_wsel = 2; id_memread = 1;
  endtask

  initial begin
    idle();
    for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_w[i] = 0; m_l[i] = 0; end
    m_dw = 0; m_cnt = 0;

    // Load-use
    rst();
    lw2();  step("lw");  chk("lw_outs", {9'd0, s_out}, {9'd0, NORM});
    use2(); step("lu1"); chk("lu1_outs", {9'd0, s_out}, {9'd0, STALL});
`ifdef FORWARDING_EN
    step("lu2"); chk("lu2_outs", {9'd0, s_out}, {9'd0, NORM}); chk("lu_cnt", s_cnt, 16'd1);
`else
    step("lu2"); chk("lu2_outs", {9'd0, s_out}, {9'd0, STALL});
    step("lu3"); chk("lu3_outs", {9'd0, s_out}, {9'd0, STALL});
    step("lu4"); chk("lu4_outs", {9'd0, s_out}, {9'd0, NORM}); chk("lu_cnt", s_cnt, 16'd3);
`endif

    // $0 destination never stalls
    rst();
    idle(); id_regwr = 1; id_memread = 1; step("lw0");
    idle(); id_rs = 0; id_rs_used = 1; id_rt_used = 1;
    for (int i = 0; i < 3; i++) begin
      step("z0"); chk("z0_outs", {9'd0, s_out}, {9'd0, NORM});
    end
    chk("z0_cnt", s_cnt, 16'd0);

    // Data wait
    rst();
    idle(); mem_dreq = 1; dhit = 0;
    for (int i = 0; i < 4; i++) begin
      step("dw"); chk("dw_outs", {9'd0, s_out}, {9'd0, ALL0});
    end
    dhit = 1;     step("dw_exit"); chk("dw_exit", {9'd0, s_out}, {9'd0, NORM});
    mem_dreq = 0; step("dw_after"); chk("dw_after", {9'd0, s_out}, {9'd0, NORM});

    // Redirect beats load-use
    rst();
    lw2(); step("lw_r");
    use2(); ex_redirect = 1; step("redir"); chk("redir_outs", {9'd0, s_out}, {9'd0, REDIR});
    idle(); step("redir_n"); chk("redir_cnt", s_cnt, 16'd0);

    // Fetch miss
    rst();
    idle(); ihit = 0;
    for (int i = 0; i < 2; i++) begin
      step("im"); chk("im_outs", {9'd0, s_out}, {9'd0, STALL});
    end
    ihit = 1; step("im_exit"); chk("im_exit", {9'd0, s_out}, {9'd0, NORM});

    // Reset during DWAIT
    rst();
    lw2(); step("lw_d");
    idle(); mem_dreq = 1; dhit = 0; step("dw_a"); step("dw_b");
    chk("dw_b_outs", {9'd0, s_out}, {9'd0, ALL0});
    nRST = 0; step("dw_rst"); chk("dw_rst", {9'd0, s_out}, {9'd0, ALL0});
    nRST = 1; use2(); step("post_rst"); chk("post_rst", {9'd0, s_out}, {9'd0, NORM});
    idle(); step("gap"); step("gap"); step("gap");
    idle(); id_regwr = 1; id_wsel = 2; step("add2");
    idle(); id_rs = 2; id_rs_used = 1; id_regwr = 1; id_wsel = 5;
`ifdef FORWARDING_EN
    step("sub"); chk("sub_outs", {9'd0, s_out}, {9'd0, NORM});
`else
    for (int i = 0; i < 3; i++) begin
      step("sub"); chk("sub_outs", {9'd0, s_out}, {9'd0, STALL});
    end
    step("sub_go"); chk("sub_go", {9'd0, s_out}, {9'd0, NORM});
`endif

    // Randomized traffic
    rst();
    for (int c = 0; c < 3000; c++) begin
      nRST        = ($urandom % 80) != 0;
      ihit        = ($urandom % 100) < 85;
      dhit        = ($urandom % 100) < 75;
      mem_dreq    = ($urandom % 100) < 30;
      ex_redirect = ($urandom % 100) < 10;
      id_rs       = 5'($urandom % 6);
      id_rt       = 5'($urandom % 6);
      id_rs_used  = 1'($urandom);
      id_rt_used  = 1'($urandom);
      id_regwr    = ($urandom % 100) < 70;
      id_wsel     = 5'($urandom % 6);
      id_memread  = 1'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
